// File: rtl/mux4to1_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 WIDTH-bit mux between four requesters (optional MUX_ARB_XFER_CNT_EN adds xfer_cnt).
// Latency: a request seen in IDLE raises out_valid one cycle later; back-to-back grants add no bubble.
// Backpressure: while out_ready is low the grant, out_sel and out_valid hold, and no ack is issued.

module mux4to1_16bit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    // Plain combinational 4:1 select.
    always_comb begin
        out = in0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

module mux4to1_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MUX_ARB_XFER_CNT_EN
    output logic [15:0]      xfer_cnt,
`endif
    output logic [1:0]       out_sel
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] ptr;
    logic [1:0] next_ptr;
    logic [1:0] next_sel;
    logic       next_valid;
    logic       xfer;
    logic [2:0] pick;
    logic [WIDTH-1:0] mux_out;

    // Search mask starting at index start, wrapping mod 4; returns {found, index}.
    // Walking the offsets from far to near lets the nearest hit overwrite the others.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    mux4to1_16bit #(.WIDTH(WIDTH)) u_mux (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (out_sel),
        .out (mux_out)
    );

    assign xfer     = out_valid && out_ready;
    assign out_data = out_valid ? mux_out : '0;

    // Next-state, grant search and ack generation.
    always_comb begin
        next_state = state;
        next_sel   = out_sel;
        next_valid = out_valid;
        next_ptr   = ptr;
        ack        = 4'b0000;
        pick       = 3'b000;
        case (state)
            IDLE: begin
                pick = rr_pick(req, ptr);
                if (pick[2]) begin
                    next_sel   = pick[1:0];
                    next_valid = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    ack      = 4'b0001 << out_sel;
                    next_ptr = out_sel + 2'd1;
                    // The requester just served is masked so a re-raised req waits a cycle.
                    pick     = rr_pick(req & ~(4'b0001 << out_sel), out_sel + 2'd1);
                    if (pick[2]) begin
                        next_sel = pick[1:0];
                    end else begin
                        next_valid = 1'b0;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_valid = 1'b0;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
        end else begin
            state     <= next_state;
            out_valid <= next_valid;
            out_sel   <= next_sel;
            ptr       <= next_ptr;
        end
    end

`ifdef MUX_ARB_XFER_CNT_EN
    // Free-running count of completed transfers, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt <= 16'd0;
        end else if (xfer) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux4to1_rr_arbiter.sv
// Directed bench for mux4to1_rr_arbiter with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge; outputs are checked before the next edge.
// Covers reset, single grant, full contention, backpressure, wrap/skip, mid-transfer reset.

module tb_mux4to1_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] in0, in1, in2, in3;
    logic [3:0]  ack;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;
`ifdef MUX_ARB_XFER_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux4to1_rr_arbiter #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MUX_ARB_XFER_CNT_EN
        .xfer_cnt  (xfer_cnt),
`endif
        .out_sel   (out_sel)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        req   = 4'b0000;
        repeat (cycles) step();
        reset = 1'b0;
        #1;
    endtask

    logic [15:0] exp_data [4];

    initial begin
        in0 = 16'hFFFF; in1 = 16'h0000; in2 = 16'hFE00; in3 = 16'h01FF;
        exp_data[0] = 16'hFFFF; exp_data[1] = 16'h0000;
        exp_data[2] = 16'hFE00; exp_data[3] = 16'h01FF;
        out_ready = 1'b1;
        req = 4'b0000;
        reset = 1'b1;
        #1;

        // Reset state
        do_reset(2);
        check_val("rst_valid", {31'd0, out_valid}, 0);
        check_val("rst_sel",   {30'd0, out_sel}, 0);
        check_val("rst_ack",   {28'd0, ack}, 0);
        check_val("rst_data",  {16'd0, out_data}, 0);

        // Single request from requester 2
        req = 4'b0100;
        #1;
        check_val("idle_ack", {28'd0, ack}, 0);
        step();
        check_val("single_valid", {31'd0, out_valid}, 1);
        check_val("single_sel",   {30'd0, out_sel}, 2);
        check_val("single_data",  {16'd0, out_data}, 32'hFE00);
        check_val("single_ack",   {28'd0, ack}, 32'h4);
        step();
        req = 4'b0000;
        #1;
        check_val("single_done_valid", {31'd0, out_valid}, 0);
        check_val("single_done_data",  {16'd0, out_data}, 0);
        check_val("single_done_ack",   {28'd0, ack}, 0);

        // Full contention: grants rotate 0,1,2,3,0
        do_reset(1);
        req = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("cont_sel%0d", i),  {30'd0, out_sel}, i % 4);
            check_val($sformatf("cont_data%0d", i), {16'd0, out_data}, {16'd0, exp_data[i % 4]});
            check_val($sformatf("cont_ack%0d", i),  {28'd0, ack}, 32'd1 << (i % 4));
            check_val($sformatf("cont_onehot%0d", i), $countones(ack), 1);
            step();
        end

        // Backpressure on requester 1
        do_reset(1);
        out_ready = 1'b0;
        req = 4'b0010;
        step();
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("bp_valid%0d", i), {31'd0, out_valid}, 1);
            check_val($sformatf("bp_sel%0d", i),   {30'd0, out_sel}, 1);
            check_val($sformatf("bp_data%0d", i),  {16'd0, out_data}, 0);
            check_val($sformatf("bp_ack%0d", i),   {28'd0, ack}, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_ack_ready", {28'd0, ack}, 32'h2);
        step();
        req = 4'b0000;
        #1;
        check_val("bp_done_valid", {31'd0, out_valid}, 0);

        // Wrap-around and skip: last grant 3, then req=1010
        do_reset(1);
        req = 4'b1000;
        step();
        check_val("wrap_first_sel", {30'd0, out_sel}, 3);
        check_val("wrap_first_ack", {28'd0, ack}, 32'h8);
        step();
        req = 4'b1010;
        #1;
        check_val("wrap_idle_valid", {31'd0, out_valid}, 0);
        step();
        check_val("wrap_sel1", {30'd0, out_sel}, 1);
        check_val("wrap_ack1", {28'd0, ack}, 32'h2);
        step();
        req = 4'b1000;
        #1;
        check_val("wrap_sel3",   {30'd0, out_sel}, 3);
        check_val("wrap_data3",  {16'd0, out_data}, 32'h01FF);
        check_val("wrap_ack3",   {28'd0, ack}, 32'h8);
        step();
        req = 4'b1001;
        #1;
        check_val("wrap_idle2_valid", {31'd0, out_valid}, 0);
        step();
        check_val("wrap_ptr0_sel", {30'd0, out_sel}, 0);

        // Reset in the middle of a stalled transfer
        do_reset(1);
        out_ready = 1'b0;
        req = 4'b0100;
        step();
        check_val("mid_busy_sel",   {30'd0, out_sel}, 2);
        check_val("mid_busy_valid", {31'd0, out_valid}, 1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_ack", {28'd0, ack}, 0);
        step();
        reset = 1'b0;
        #1;
        check_val("mid_after_valid", {31'd0, out_valid}, 0);
        check_val("mid_after_sel",   {30'd0, out_sel}, 0);
        check_val("mid_after_ack",   {28'd0, ack}, 0);
        check_val("mid_after_data",  {16'd0, out_data}, 0);
        step();
        check_val("mid_regrant_valid", {31'd0, out_valid}, 1);
        check_val("mid_regrant_sel",   {30'd0, out_sel}, 2);
        out_ready = 1'b1;

`ifdef MUX_ARB_XFER_CNT_EN
        // Saturated run to exercise counter wrap
        do_reset(1);
        check_val("cnt_rst", {16'd0, xfer_cnt}, 0);
        out_ready = 1'b1;
        req = 4'b1111;
        step();
        repeat (70000) @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        check_val("cnt_wrap", {16'd0, xfer_cnt}, 32'd4464);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4to1_rr_arbiter.md
Name: mux4to1_rr_arbiter

Overview:
- Shares one 4:1 WIDTH-bit mux datapath (instance of mux4to1_16bit) between four requesters using round-robin arbitration and a valid/ready output handshake.
- Sequences the mux select from requester activity instead of from a testbench-driven sel.
- Sits between four independent data producers and a single downstream consumer.
- Provides fair access, one transfer per cycle under continuous contention, and a per-requester ack.

Parameters:
WIDTH, 16, data width of each input and of out_data; must match the mux instance width.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  4  req[i]=1: requester i has data on in_i; held high until ack[i]
in0  input  WIDTH  requester 0 data; stable while req[0]=1
in1  input  WIDTH  requester 1 data
in2  input  WIDTH  requester 2 data
in3  input  WIDTH  requester 3 data
ack  output  4  one-hot, combinational; ack[i]=1 in the cycle requester i's word is accepted downstream
out_data  output  WIDTH  mux output of selected input; forced 0 when out_valid=0
out_valid  output  1  registered; word on out_data is valid
out_ready  input  1  consumer accepts when out_valid && out_ready (handshake "xfer")
out_sel  output  2  registered index of the granted requester (drives mux sel)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, out_sel=0, ptr=0, ack=0, out_data=0. Reset asserted mid-transfer aborts it. No ack is issued, and the pending word is not transferred.
- State IDLE (out_valid=0):
  - If req!=0, pick the winner with a round-robin search starting at index ptr: ptr, ptr+1, ... mod 4. The first index with req[i]=1 wins.
  - Next edge: out_sel<=winner, out_valid<=1, state<=BUSY.
  - If req==0, stay in IDLE.
- State BUSY (out_valid=1):
  - out_data = in[out_sel], taken combinationally through the mux instance.
  - Without xfer: all state holds, and out_data tracks in[out_sel].
  - On xfer:
    - ack[out_sel]=1 in that same cycle.
    - ptr<=out_sel+1 (mod 4, wraps 3->0).
    - Re-arbitrate over req & ~(1<<out_sel), starting at out_sel+1.
    - If there is a winner: out_sel<=winner, stay in BUSY (back-to-back, no bubble).
    - Otherwise: out_valid<=0, state<=IDLE.
- Latency: a req rising in IDLE produces out_valid 1 cycle later. Under saturation, throughput is 1 xfer per cycle.
- Fairness: a continuously requesting requester waits at most 3 transfers between grants.
- Requester protocol: req[i] may only drop the cycle after ack[i]. If the granted requester drops req early, the block ignores it and the transfer still completes with current in[out_sel].
- A re-asserted req from the just-acked requester is not eligible in the ack cycle. It competes from the next cycle onward.
- ack is never asserted when out_valid=0 or out_ready=0. At most one ack bit is high in any cycle.
- out_ready is ignored in IDLE.

Optional Feature:
- Macro: MUX_ARB_XFER_CNT_EN.
- When defined:
  - Adds output port xfer_cnt [15:0], a registered count of completed xfers.
  - Increments by 1 per xfer and wraps 0xFFFF->0x0000.
  - Reset value 0.
- When undefined: the port and counter logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then single request: reset 2 cycles, in0=16'hFFFF, in1=16'h0000, in2=16'hFE00, in3=16'h01FF, req=4'b0100, out_ready=1.
  - Next cycle: out_valid=1, out_sel=2, out_data=16'hFE00, ack=4'b0100.
  - After req drops: out_valid=0 and out_data=0 the following cycle.
- Full contention: same inputs, req=4'b1111 held (each requester re-raises req after its ack), out_ready=1.
  - Grant order after reset is 0,1,2,3,0,... with out_data FFFF,0000,FE00,01FF,FFFF on consecutive cycles.
  - Exactly one ack bit per cycle.
- Backpressure: req=4'b0010, out_ready=0 for 5 cycles, then 1.
  - out_valid=1, out_sel=1, out_data=0000 held for 5 cycles with ack=0.
  - ack=4'b0010 on the ready cycle.
- Wrap-around and skip: last grant was 3; then req=4'b1010.
  - Next grant is 1 (search 0 finds none), then 3.
  - ptr wraps to 0 after the 3 grant.
- Reset mid-operation: BUSY with out_sel=2 and out_ready=0; assert reset 1 cycle.
  - Next cycle: out_valid=0, out_sel=0, no ack issued.
  - With req=4'b0100 still high, re-grant to 2 one cycle after reset deasserts.
- MUX_ARB_XFER_CNT_EN: run 70000 saturated xfers.
  - xfer_cnt == 70000 mod 65536 = 4464.
  - Also compile without the macro and confirm the port is absent and the other scenarios still pass.
